regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter C_XLEN, default 32, the register data width.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port clk_en_i  input  1  global clock enable.
REQ-005 SHALL have, for each source N in 0..2 (0=ALU, 1=LSU, 2=MDU/CSR), these ports:
- srcN_valid_i  input  1  write request.
- srcN_addr_i  input  5  destination register.
- srcN_data_i  input  C_XLEN  write data.
- srcN_ready_o  output  1  request accepted this cycle.
REQ-006 SHALL have, for each write port P in a, b, these ports:
- wreg_P_wr_o  output  1  write strobe.
- wreg_P_addr_o  output  5  register address.
- wreg_P_data_o  output  C_XLEN  write data.

Function
REQ-007 SHALL accept a transfer on source N when srcN_valid_i and srcN_ready_o are both high; srcN_ready_o SHALL be combinational from the current request inputs and the round-robin state.
REQ-008 SHALL assign priority order rr_q, rr_q+1, rr_q+2 (mod 3), where rr_q is a 2-bit round-robin pointer taking only the values 0..2.
REQ-009 SHALL grant at most two requests per cycle, choosing valid requests in priority order; port A SHALL take the first grant and port B the second.
REQ-010 SHALL accept a valid request with addr 0 (ready high) without consuming a port, and SHALL NOT emit it on either write port.
REQ-011 SHALL refuse (ready low) a valid request whose nonzero address equals that of an already-granted request in the same cycle; the refused request retries next cycle.
REQ-012 SHALL register granted writes: each write appears on wreg_P_* exactly one cycle after acceptance; wreg_P_wr_o SHALL be low in any cycle following a cycle with no grant for port P.
REQ-013 SHALL advance rr_q by one (2 wraps to 0) at the end of any cycle in which at least one valid request was refused; otherwise rr_q SHALL hold.
REQ-014 SHALL hold all srcN_ready_o low while clk_en_i is low, and SHALL hold rr_q and all outputs unchanged in that case.
REQ-015 SHALL require sources to hold addr and data stable while valid is high and ready is low; the block does not buffer refused requests.

Reset
REQ-016 SHALL, while reset_i is high at a clock edge, set rr_q to 0 and all wreg_P_wr_o, wreg_P_addr_o and wreg_P_data_o to 0, regardless of clk_en_i.
REQ-017 SHALL drive all srcN_ready_o low while reset_i is high; a reset mid-operation discards pending output writes.

Configuration
REQ-018 SHALL, when macro REGFILE_WB_BYPASS_EN is defined, add these ports:
- rreg_a_addr_i  input  5
- rreg_b_addr_i  input  5
- byp_a_hit_o  output  1
- byp_a_data_o  output  C_XLEN
- byp_b_hit_o  output  1
- byp_b_data_o  output  C_XLEN
REQ-019 SHALL, with REGFILE_WB_BYPASS_EN defined, drive byp_X_hit_o combinationally high when rreg_X_addr_i is nonzero and equals the address of an asserted wreg_P_*, with byp_X_data_o equal to that port's data; otherwise byp_X_hit_o is 0 and byp_X_data_o is 0.
REQ-020 SHALL, without REGFILE_WB_BYPASS_EN, omit these ports and the associated logic entirely.

Structure
REQ-021 SHALL take the source indices, source count (3) and the write-request struct (addr, data) from a shared package, regfile_wb_pkg.
REQ-022 SHALL implement the two-winner priority/conflict selection in one combinational sub-module, regfile_wb_rr_select.

Verification
REQ-023 Reset, then src0 and src1 valid (addr 5, 6; data 0xA, 0xB) -> both ready; next cycle port A = (5, 0xA), port B = (6, 0xB); rr_q stays 0.
REQ-024 All three sources valid (addr 1, 2, 3) with rr_q=0 -> src0 and src1 granted, src2 refused, rr_q becomes 1; next cycle src2 is granted on port A.
REQ-025 src0 and src2 both target addr 7 -> only the higher-priority source is granted; the other is granted the following cycle; no cycle has both ports at addr 7.
REQ-026 src1 addr 0 plus src0 addr 4 -> both ready; only port A writes (4, data); port B strobe stays low.
REQ-027 clk_en_i low for 3 cycles with requests pending -> no ready, outputs and rr_q frozen; reset_i asserted mid-stream -> outputs 0 and rr_q 0 on the next edge.
REQ-028 With REGFILE_WB_BYPASS_EN, write (9, 0x1234) on port B and rreg_a_addr_i=9 -> byp_a_hit_o=1 and byp_a_data_o=0x1234; rreg_a_addr_i=0 -> byp_a_hit_o=0.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Source indices, source count and the write-request bundle.
package regfile_wb_pkg;

  localparam int unsigned SRC_N       = 3;
  localparam int unsigned SRC_ALU     = 0;
  localparam int unsigned SRC_LSU     = 1;
  localparam int unsigned SRC_MDU     = 2;
  localparam int unsigned WB_MAX_XLEN = 64;

  typedef logic [1:0] src_idx_t;

  // data is sized for the widest supported XLEN; users zero-extend
  typedef struct packed {
    logic [4:0]             addr;
    logic [WB_MAX_XLEN-1:0] data;
  } wb_req_t;

  function automatic src_idx_t rr_inc(src_idx_t i);
    return (i == src_idx_t'(SRC_N - 1)) ? '0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/regfile_wb_rr_select.sv
// Two-winner round-robin selection with same-address conflict refusal.
// Address 0 requests are accepted but never occupy a write port.
import regfile_wb_pkg::*;

module regfile_wb_rr_select (
  input  logic                  en_i,
  input  src_idx_t              rr_i,
  input  logic [SRC_N-1:0]      valid_i,
  input  logic [SRC_N-1:0][4:0] addr_i,
  output logic [SRC_N-1:0]      ready_o,
  output logic                  gnt_a_o,
  output src_idx_t              gnt_a_idx_o,
  output logic                  gnt_b_o,
  output src_idx_t              gnt_b_idx_o,
  output logic                  refused_o
);

  src_idx_t idx;

  always_comb begin
    ready_o     = '0;
    gnt_a_o     = 1'b0;
    gnt_a_idx_o = '0;
    gnt_b_o     = 1'b0;
    gnt_b_idx_o = '0;
    refused_o   = 1'b0;
    idx         = rr_i;
    for (int k = 0; k < SRC_N; k++) begin
      if (en_i && valid_i[idx]) begin
        if (addr_i[idx] == 5'd0) begin
          ready_o[idx] = 1'b1;
        end else if (!gnt_a_o) begin
          gnt_a_o      = 1'b1;
          gnt_a_idx_o  = idx;
          ready_o[idx] = 1'b1;
        end else if (!gnt_b_o &&
                     addr_i[idx] != addr_i[gnt_a_idx_o]) begin
          gnt_b_o      = 1'b1;
          gnt_b_idx_o  = idx;
          ready_o[idx] = 1'b1;
        end else begin
          refused_o = 1'b1;
        end
      end
      idx = rr_inc(idx);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Three-source, two-port register-file writeback arbiter.
// Optional forwarding of registered writes under REGFILE_WB_BYPASS_EN.
import regfile_wb_pkg::*;

module regfile_wb_arbiter #(
  parameter int unsigned C_XLEN = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_en_i,
  input  logic              src0_valid_i,
  input  logic [4:0]        src0_addr_i,
  input  logic [C_XLEN-1:0] src0_data_i,
  output logic              src0_ready_o,
  input  logic              src1_valid_i,
  input  logic [4:0]        src1_addr_i,
  input  logic [C_XLEN-1:0] src1_data_i,
  output logic              src1_ready_o,
  input  logic              src2_valid_i,
  input  logic [4:0]        src2_addr_i,
  input  logic [C_XLEN-1:0] src2_data_i,
  output logic              src2_ready_o,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic [4:0]        rreg_a_addr_i,
  input  logic [4:0]        rreg_b_addr_i,
  output logic              byp_a_hit_o,
  output logic [C_XLEN-1:0] byp_a_data_o,
  output logic              byp_b_hit_o,
  output logic [C_XLEN-1:0] byp_b_data_o,
`endif
  output logic              wreg_a_wr_o,
  output logic [4:0]        wreg_a_addr_o,
  output logic [C_XLEN-1:0] wreg_a_data_o,
  output logic              wreg_b_wr_o,
  output logic [4:0]        wreg_b_addr_o,
  output logic [C_XLEN-1:0] wreg_b_data_o
);

  logic [SRC_N-1:0]      valid;
  logic [SRC_N-1:0]      ready;
  logic [SRC_N-1:0][4:0] addr;
  wb_req_t [SRC_N-1:0]   req;
  logic                  gnt_a, gnt_b, refused;
  src_idx_t              gnt_a_idx, gnt_b_idx;

  src_idx_t          rr_q, rr_d;
  logic              wr_a_q, wr_a_d, wr_b_q, wr_b_d;
  logic [4:0]        addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [C_XLEN-1:0] data_a_q, data_a_d, data_b_q, data_b_d;

  always_comb begin
    valid = {src2_valid_i, src1_valid_i, src0_valid_i};
    req[SRC_ALU] = '{addr: src0_addr_i,
                     data: WB_MAX_XLEN'(src0_data_i)};
    req[SRC_LSU] = '{addr: src1_addr_i,
                     data: WB_MAX_XLEN'(src1_data_i)};
    req[SRC_MDU] = '{addr: src2_addr_i,
                     data: WB_MAX_XLEN'(src2_data_i)};
    for (int i = 0; i < SRC_N; i++) addr[i] = req[i].addr;
  end

  regfile_wb_rr_select u_sel (
    .en_i        (clk_en_i & ~reset_i),
    .rr_i        (rr_q),
    .valid_i     (valid),
    .addr_i      (addr),
    .ready_o     (ready),
    .gnt_a_o     (gnt_a),
    .gnt_a_idx_o (gnt_a_idx),
    .gnt_b_o     (gnt_b),
    .gnt_b_idx_o (gnt_b_idx),
    .refused_o   (refused)
  );

  assign src0_ready_o = ready[SRC_ALU];
  assign src1_ready_o = ready[SRC_LSU];
  assign src2_ready_o = ready[SRC_MDU];

  // addr/data hold when a port idles; only the strobe drops
  always_comb begin
    rr_d     = rr_q;
    wr_a_d   = wr_a_q;
    addr_a_d = addr_a_q;
    data_a_d = data_a_q;
    wr_b_d   = wr_b_q;
    addr_b_d = addr_b_q;
    data_b_d = data_b_q;
    if (clk_en_i) begin
      wr_a_d = gnt_a;
      wr_b_d = gnt_b;
      if (gnt_a) begin
        addr_a_d = req[gnt_a_idx].addr;
        data_a_d = C_XLEN'(req[gnt_a_idx].data);
      end
      if (gnt_b) begin
        addr_b_d = req[gnt_b_idx].addr;
        data_b_d = C_XLEN'(req[gnt_b_idx].data);
      end
      if (refused) rr_d = rr_inc(rr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q     <= '0;
      wr_a_q   <= 1'b0;
      addr_a_q <= '0;
      data_a_q <= '0;
      wr_b_q   <= 1'b0;
      addr_b_q <= '0;
      data_b_q <= '0;
    end else begin
      rr_q     <= rr_d;
      wr_a_q   <= wr_a_d;
      addr_a_q <= addr_a_d;
      data_a_q <= data_a_d;
      wr_b_q   <= wr_b_d;
      addr_b_q <= addr_b_d;
      data_b_q <= data_b_d;
    end
  end

  assign wreg_a_wr_o   = wr_a_q;
  assign wreg_a_addr_o = addr_a_q;
  assign wreg_a_data_o = data_a_q;
  assign wreg_b_wr_o   = wr_b_q;
  assign wreg_b_addr_o = addr_b_q;
  assign wreg_b_data_o = data_b_q;

`ifdef REGFILE_WB_BYPASS_EN
  always_comb begin
    byp_a_hit_o  = 1'b0;
    byp_a_data_o = '0;
    if (rreg_a_addr_i != 5'd0) begin
      if (wr_a_q && addr_a_q == rreg_a_addr_i) begin
        byp_a_hit_o  = 1'b1;
        byp_a_data_o = data_a_q;
      end else if (wr_b_q && addr_b_q == rreg_a_addr_i) begin
        byp_a_hit_o  = 1'b1;
        byp_a_data_o = data_b_q;
      end
    end
  end

  always_comb begin
    byp_b_hit_o  = 1'b0;
    byp_b_data_o = '0;
    if (rreg_b_addr_i != 5'd0) begin
      if (wr_a_q && addr_a_q == rreg_b_addr_i) begin
        byp_b_hit_o  = 1'b1;
        byp_b_data_o = data_a_q;
      end else if (wr_b_q && addr_b_q == rreg_b_addr_i) begin
        byp_b_hit_o  = 1'b1;
        byp_b_data_o = data_b_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a queue-based model.
// Directed scenarios first, then constrained-random traffic.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst, en;
  logic        v[3];
  logic [4:0]  a[3];
  logic [31:0] d[3];
  logic        rdy[3];
  logic        w_wr[2];
  logic [4:0]  w_addr[2];
  logic [31:0] w_data[2];
`ifdef REGFILE_WB_BYPASS_EN
  logic [4:0]  rr_addr[2];
  logic        byp_hit[2];
  logic [31:0] byp_data[2];
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.C_XLEN(32)) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .clk_en_i      (en),
    .src0_valid_i  (v[0]),
    .src0_addr_i   (a[0]),
    .src0_data_i   (d[0]),
    .src0_ready_o  (rdy[0]),
    .src1_valid_i  (v[1]),
    .src1_addr_i   (a[1]),
    .src1_data_i   (d[1]),
    .src1_ready_o  (rdy[1]),
    .src2_valid_i  (v[2]),
    .src2_addr_i   (a[2]),
    .src2_data_i   (d[2]),
    .src2_ready_o  (rdy[2]),
`ifdef REGFILE_WB_BYPASS_EN
    .rreg_a_addr_i (rr_addr[0]),
    .rreg_b_addr_i (rr_addr[1]),
    .byp_a_hit_o   (byp_hit[0]),
    .byp_a_data_o  (byp_data[0]),
    .byp_b_hit_o   (byp_hit[1]),
    .byp_b_data_o  (byp_data[1]),
`endif
    .wreg_a_wr_o   (w_wr[0]),
    .wreg_a_addr_o (w_addr[0]),
    .wreg_a_data_o (w_data[0]),
    .wreg_b_wr_o   (w_wr[1]),
    .wreg_b_addr_o (w_addr[1]),
    .wreg_b_data_o (w_data[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // model state
  int          m_rr;
  bit          m_wr[2];
  logic [4:0]  m_addr[2];
  logic [31:0] m_data[2];
  bit          exp_rdy[3];
  bit          m_refused;
  int          nxt_n;
  logic [4:0]  nxt_addr[2];
  logic [31:0] nxt_data[2];

  function automatic void predict();
    int taken[$];
    bit clash;
    int s;
    nxt_n     = 0;
    m_refused = 0;
    for (int i = 0; i < 3; i++) exp_rdy[i] = 0;
    if (rst || !en) return;
    for (int k = 0; k < 3; k++) begin
      s = (m_rr + k) % 3;
      if (v[s]) begin
        clash = 0;
        foreach (taken[j]) if (taken[j] == int'(a[s])) clash = 1;
        if (a[s] == 0) exp_rdy[s] = 1;
        else if (nxt_n < 2 && !clash) begin
          exp_rdy[s] = 1;
          taken.push_back(int'(a[s]));
          nxt_addr[nxt_n] = a[s];
          nxt_data[nxt_n] = d[s];
          nxt_n++;
        end else m_refused = 1;
      end
    end
  endfunction

  task automatic cycle(input string tag);
    bit was_rst;
    #1;
    predict();
    for (int i = 0; i < 3; i++)
      check($sformatf("%s_rdy%0d", tag, i), rdy[i], exp_rdy[i]);
    was_rst = rst;
    @(posedge clk);
    if (rst) begin
      m_rr = 0;
      for (int p = 0; p < 2; p++) begin
        m_wr[p] = 0; m_addr[p] = 0; m_data[p] = 0;
      end
    end else if (en) begin
      for (int p = 0; p < 2; p++) begin
        m_wr[p] = (p < nxt_n);
        if (p < nxt_n) begin
          m_addr[p] = nxt_addr[p];
          m_data[p] = nxt_data[p];
        end
      end
      if (m_refused) m_rr = (m_rr + 1) % 3;
    end
    #1;
    for (int p = 0; p < 2; p++) begin
      check($sformatf("%s_wr%0d", tag, p), w_wr[p], m_wr[p]);
      if (m_wr[p] || was_rst) begin
        check($sformatf("%s_addr%0d", tag, p), w_addr[p], m_addr[p]);
        check($sformatf("%s_data%0d", tag, p), w_data[p], m_data[p]);
      end
    end
    check({tag, "_rr"}, dut.rr_q, m_rr);
`ifdef REGFILE_WB_BYPASS_EN
    for (int r = 0; r < 2; r++) begin
      bit          eh = 0;
      logic [31:0] ed = 0;
      for (int p = 1; p >= 0; p--)
        if (rr_addr[r] != 0 && m_wr[p] && m_addr[p] == rr_addr[r]) begin
          eh = 1; ed = m_data[p];
        end
      check($sformatf("%s_bhit%0d", tag, r), byp_hit[r], eh);
      check($sformatf("%s_bdat%0d", tag, r), byp_data[r], ed);
    end
`endif
    @(negedge clk);
  endtask

  task automatic retire();
    for (int i = 0; i < 3; i++) if (exp_rdy[i]) v[i] = 0;
  endtask

  task automatic req(input int s, input logic [4:0] ad,
                     input logic [31:0] dt);
    v[s] = 1; a[s] = ad; d[s] = dt;
  endtask

  initial begin
    rst = 1; en = 1;
    for (int i = 0; i < 3; i++) begin v[i] = 0; a[i] = 0; d[i] = 0; end
`ifdef REGFILE_WB_BYPASS_EN
    rr_addr[0] = 0; rr_addr[1] = 0;
`endif
    m_rr = 0;
    for (int p = 0; p < 2; p++) begin m_wr[p] = 0; m_addr[p] = 0; m_data[p] = 0; end
    @(negedge clk);
    cycle("rst0");
    cycle("rst1");
    rst = 0;

    req(0, 5, 32'hA); req(1, 6, 32'hB);
    cycle("t23");
    check("t23_a_addr", w_addr[0], 5);
    check("t23_a_data", w_data[0], 32'hA);
    check("t23_b_addr", w_addr[1], 6);
    check("t23_b_data", w_data[1], 32'hB);
    check("t23_rr", dut.rr_q, 0);
    retire();

    req(0, 1, 32'h11); req(1, 2, 32'h22); req(2, 3, 32'h33);
    cycle("t24a");
    check("t24_rr", dut.rr_q, 1);
    retire();
    cycle("t24b");
    check("t24_a_addr", w_addr[0], 3);
    check("t24_b_wr", w_wr[1], 0);
    retire();

    req(0, 7, 32'h70); req(2, 7, 32'h72);
    cycle("t25a");
    check("t25a_data", w_data[0], 32'h72);
    check("t25a_b_wr", w_wr[1], 0);
    retire();
    cycle("t25b");
    check("t25b_data", w_data[0], 32'h70);
    check("t25b_b_wr", w_wr[1], 0);
    retire();

    req(0, 4, 32'hC4); req(1, 0, 32'hD0);
    cycle("t26");
    check("t26_a_addr", w_addr[0], 4);
    check("t26_b_wr", w_wr[1], 0);
    retire();

`ifdef REGFILE_WB_BYPASS_EN
    req(0, 1, 32'h1); req(1, 9, 32'h1234);
    rr_addr[0] = 9;
    cycle("t28");
    check("t28_hit", byp_hit[0], 1);
    check("t28_data", byp_data[0], 32'h1234);
    rr_addr[0] = 0;
    #1 check("t28_hit0", byp_hit[0], 0);
    retire();
`endif

    req(0, 10, 32'h100); req(1, 11, 32'h101); req(2, 12, 32'h102);
    en = 0;
    for (int i = 0; i < 3; i++) cycle($sformatf("t27_off%0d", i));
    en = 1;
    cycle("t27_on");
    retire();
    req(0, 13, 32'h200); req(1, 14, 32'h201);
    rst = 1;
    cycle("t27_rst");
    check("t27_rst_wr", w_wr[0], 0);
    check("t27_rst_rr", dut.rr_q, 0);
    rst = 0;

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++)
        if (!v[i] || exp_rdy[i]) begin
          v[i] = ($urandom_range(0, 3) != 0);
          a[i] = 5'($urandom_range(0, 7));
          d[i] = $urandom;
        end
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 49) == 0);
`ifdef REGFILE_WB_BYPASS_EN
      rr_addr[0] = 5'($urandom_range(0, 7));
      rr_addr[1] = 5'($urandom_range(0, 7));
`endif
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
